// File: rtl/debounce_pkg.sv
// Shared defaults and threshold helpers for the debouncer family.
// Thresholds sit at 1/4 and 3/4 of the integrator range to give symmetric hysteresis.
package debounce_pkg;

  localparam int CNT_MAX_DEF  = 1024;
  localparam int LONG_CYC_DEF = 1 << 20;
  localparam int RPT_CYC_DEF  = 1 << 18;

  typedef struct packed {
    int unsigned hi;
    int unsigned lo;
  } th_t;

  function automatic th_t derive_th(input int unsigned cnt_max);
    th_t t;
    t.hi = (3 * cnt_max) / 4;
    t.lo = cnt_max / 4;
    return t;
  endfunction

  function automatic int th_hi_of(input int unsigned cnt_max);
    th_t t;
    t = derive_th(cnt_max);
    return int'(t.hi);
  endfunction

  function automatic int th_lo_of(input int unsigned cnt_max);
    th_t t;
    t = derive_th(cnt_max);
    return int'(t.lo);
  endfunction

endpackage

// File: rtl/debounce_ch.sv
// One debounce channel: 2-FF sync, saturating integrator, hysteresis level, edge/long pulses.
// Auto-repeat counter only exists when DEBOUNCE_MC_RPT_EN is defined; otherwise rpt is tied low.
module debounce_ch
  import debounce_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int CNT_MAX  = CNT_MAX_DEF,
  parameter int TH_HI    = th_hi_of(CNT_MAX),
  parameter int TH_LO    = th_lo_of(CNT_MAX),
  parameter int LONG_W   = 24,
  parameter int LONG_CYC = LONG_CYC_DEF,
  parameter int RPT_CYC  = RPT_CYC_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall,
  output logic long_pulse,
  output logic rpt
);

  localparam logic [CNT_W-1:0]  CNT_MAX_V  = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0]  TH_HI_V    = CNT_W'(TH_HI);
  localparam logic [CNT_W-1:0]  TH_LO_V    = CNT_W'(TH_LO);
  localparam logic [LONG_W-1:0] LONG_V     = LONG_W'(LONG_CYC);
  localparam logic [LONG_W-1:0] LONG_M1_V  = LONG_W'(LONG_CYC - 1);

  // The repeat counter shares the hold counter width.
  if (RPT_CYC < 1 || longint'(RPT_CYC) >= (longint'(1) << LONG_W)) begin : g_bad_rpt
    $error("debounce_ch: RPT_CYC must be in [1, 2**LONG_W)");
  end

  logic [1:0]        sync;
  logic [CNT_W-1:0]  cnt;
  logic [LONG_W-1:0] hold;
  logic              s;
  logic              above_hi;
  logic              below_lo;

  assign s        = sync[1];
  assign above_hi = (cnt > TH_HI_V);
  assign below_lo = (cnt < TH_LO_V);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync <= '0;
      cnt  <= '0;
    end else begin
      sync <= {sync[0], raw};
      if (s && (cnt < CNT_MAX_V)) begin
        cnt <= cnt + 1'b1;
      end else if (!s && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  // Level and its edge pulses are all decided from the same registered cnt.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      if (above_hi) begin
        level <= 1'b1;
      end else if (below_lo) begin
        level <= 1'b0;
      end
      rise <= above_hi & ~level;
      fall <= below_lo & level;
    end
  end

  // hold saturates at LONG_CYC so the long pulse fires once per press.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      hold       <= '0;
      long_pulse <= 1'b0;
    end else begin
      if (!level) begin
        hold <= '0;
      end else if (hold < LONG_V) begin
        hold <= hold + 1'b1;
      end
      long_pulse <= level & (hold == LONG_M1_V);
    end
  end

`ifdef DEBOUNCE_MC_RPT_EN
  localparam logic [LONG_W-1:0] RPT_M1_V = LONG_W'(RPT_CYC - 1);

  logic [LONG_W-1:0] rpt_cnt;
  logic              rpt_run;
  logic              rpt_hit;

  // Runs only once hold has saturated, i.e. from the cycle after the long pulse.
  assign rpt_run = level & (hold == LONG_V);
  assign rpt_hit = rpt_run & (rpt_cnt == RPT_M1_V);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rpt_cnt <= '0;
      rpt     <= 1'b0;
    end else begin
      rpt <= rpt_hit;
      if (!rpt_run || rpt_hit) begin
        rpt_cnt <= '0;
      end else begin
        rpt_cnt <= rpt_cnt + 1'b1;
      end
    end
  end
`else
  assign rpt = 1'b0;
`endif

endmodule

// File: rtl/debounce_mc.sv
// N_CH independent debounce channels with level, press/release, long-press and repeat pulses.
// Build with DEBOUNCE_MC_RPT_EN to enable o_rpt; without it o_rpt is constant 0.
module debounce_mc
  import debounce_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int CNT_W    = 16,
  parameter int CNT_MAX  = CNT_MAX_DEF,
  parameter int TH_HI    = th_hi_of(CNT_MAX),
  parameter int TH_LO    = th_lo_of(CNT_MAX),
  parameter int LONG_W   = 24,
  parameter int LONG_CYC = LONG_CYC_DEF,
  parameter int RPT_CYC  = RPT_CYC_DEF
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [N_CH-1:0] i_btn,
  output logic [N_CH-1:0] o_btn,
  output logic [N_CH-1:0] o_rise,
  output logic [N_CH-1:0] o_fall,
  output logic [N_CH-1:0] o_long,
  output logic [N_CH-1:0] o_rpt
);

  if (N_CH < 1) begin : g_bad_nch
    $error("debounce_mc: N_CH must be >= 1");
  end
  if (CNT_MAX < 1 || longint'(CNT_MAX) >= (longint'(1) << CNT_W)) begin : g_bad_cnt
    $error("debounce_mc: CNT_MAX must be in [1, 2**CNT_W)");
  end
  if (!(TH_LO > 0 && TH_LO < TH_HI && TH_HI < CNT_MAX)) begin : g_bad_th
    $error("debounce_mc: thresholds must satisfy 0 < TH_LO < TH_HI < CNT_MAX");
  end
  if (LONG_CYC < 1 || longint'(LONG_CYC) >= (longint'(1) << LONG_W)) begin : g_bad_long
    $error("debounce_mc: LONG_CYC must be in [1, 2**LONG_W)");
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_ch #(
      .CNT_W    (CNT_W),
      .CNT_MAX  (CNT_MAX),
      .TH_HI    (TH_HI),
      .TH_LO    (TH_LO),
      .LONG_W   (LONG_W),
      .LONG_CYC (LONG_CYC),
      .RPT_CYC  (RPT_CYC)
    ) u_ch (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .raw        (i_btn[i]),
      .level      (o_btn[i]),
      .rise       (o_rise[i]),
      .fall       (o_fall[i]),
      .long_pulse (o_long[i]),
      .rpt        (o_rpt[i])
    );
  end

endmodule

// File: tb/tb_debounce_mc.sv
// Directed bench for debounce_mc with a small integrator (CNT_MAX=16, thresholds 12/4).
// Expected latencies are counted in clock edges from the edge that first samples the new input.
module tb_debounce_mc;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic [1:0] i_btn;
  logic [1:0] o_btn, o_rise, o_fall, o_long, o_rpt;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  debounce_mc #(
    .N_CH(2), .CNT_W(16), .CNT_MAX(16), .TH_HI(12), .TH_LO(4),
    .LONG_W(24), .LONG_CYC(40), .RPT_CYC(10)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_btn(i_btn),
    .o_btn(o_btn), .o_rise(o_rise), .o_fall(o_fall), .o_long(o_long), .o_rpt(o_rpt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wait_pulse(input logic [1:0] mask, input bit use_long, input int limit, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while ((((use_long ? o_long : o_rise) & mask) == 2'b00) && n < limit);
  endtask

  initial begin
    int n;
    int rise_at, long_at, nlong, nrpt, first_rpt, other, overlap, mism, r0, r1;

    // Reset state
    i_rst = 1'b0;
    i_btn = 2'b00;
    #1 i_rst = 1'b1;
    #2;
    chk("rst_outputs", 32'({o_btn, o_rise, o_fall, o_long, o_rpt}), 32'd0);
    step(); step();
    #2 i_rst = 1'b0;
    step();
    chk("idle_outputs", 32'({o_btn, o_rise, o_fall, o_long, o_rpt}), 32'd0);

    // 1: press ch0, level and rise appear on edge k+15
    i_btn = 2'b01;
    repeat (15) step();
    chk("t1_btn_before", 32'(o_btn), 32'd0);
    step();
    chk("t1_btn", 32'(o_btn), 32'd1);
    chk("t1_rise", 32'(o_rise), 32'd1);
    step();
    chk("t1_rise_gone", 32'(o_rise), 32'd0);
    chk("t1_btn_held", 32'(o_btn), 32'd1);
    repeat (8) step();

    // 2: release from saturation, fall on edge k+15
    i_btn = 2'b00;
    repeat (15) step();
    chk("t2_btn_before", 32'(o_btn), 32'd1);
    step();
    chk("t2_btn", 32'(o_btn), 32'd0);
    chk("t2_fall", 32'(o_fall), 32'd1);
    step();
    chk("t2_fall_gone", 32'(o_fall), 32'd0);
    chk("t2_no_long", 32'(o_long), 32'd0);
    repeat (30) step();

    // 3: 6-on/6-off chatter never reaches the upper threshold
    other = 0;
    for (int r = 0; r < 10; r++) begin
      i_btn = 2'b01;
      for (int c = 0; c < 6; c++) begin
        step();
        if ((o_btn | o_rise | o_fall) != 2'b00) other++;
      end
      i_btn = 2'b00;
      for (int c = 0; c < 6; c++) begin
        step();
        if ((o_btn | o_rise | o_fall) != 2'b00) other++;
      end
    end
    chk("t3_glitch_quiet", 32'(other), 32'd0);
    repeat (10) step();

    // 4: hold ch1 for 100 cycles
    i_btn = 2'b10;
    rise_at = 0; long_at = 0; nlong = 0; nrpt = 0; first_rpt = 0; other = 0; overlap = 0;
    for (int c = 1; c <= 100; c++) begin
      step();
      if (o_rise[1]) rise_at = c;
      if (o_long[1]) begin nlong++; long_at = c; end
      if (o_rpt[1]) begin nrpt++; if (first_rpt == 0) first_rpt = c; end
      if ((o_btn[0] | o_rise[0] | o_fall[0] | o_long[0] | o_rpt[0]) != 1'b0) other++;
      if ((o_rise & o_fall) != 2'b00) overlap++;
    end
    chk("t4_rise_at", 32'(rise_at), 32'd16);
    chk("t4_long_at", 32'(long_at), 32'd56);
    chk("t4_long_count", 32'(nlong), 32'd1);
`ifdef DEBOUNCE_MC_RPT_EN
    chk("t4_rpt_count", 32'(nrpt), 32'd4);
    chk("t4_rpt_first", 32'(first_rpt), 32'd66);
`else
    chk("t4_rpt_count", 32'(nrpt), 32'd0);
`endif
    chk("t4_ch0_quiet", 32'(other), 32'd0);
    chk("t4_no_overlap", 32'(overlap), 32'd0);
    i_btn = 2'b00;
    repeat (40) step();
    chk("t4_released", 32'({o_btn, o_rpt}), 32'd0);

    // 5: reset in the middle of a press, then re-integrate from zero
    i_btn = 2'b01;
    wait_pulse(2'b01, 1'b0, 40, n);
    chk("t5_first_rise", 32'(n), 32'd16);
    repeat (30) step();
    #2 i_rst = 1'b1;
    #1;
    chk("t5_rst_outputs", 32'({o_btn, o_rise, o_fall, o_long, o_rpt}), 32'd0);
    step();
    chk("t5_rst_no_fall", 32'({o_btn, o_fall}), 32'd0);
    #2 i_rst = 1'b0;
    wait_pulse(2'b01, 1'b0, 40, n);
    chk("t5_rise_after_rst", 32'(n), 32'd16);
    wait_pulse(2'b01, 1'b1, 60, n);
    chk("t5_long_after_rise", 32'(n), 32'd40);
    i_btn = 2'b00;
    repeat (40) step();

    // 6: both channels pressed on the same edge
    i_btn = 2'b11;
    mism = 0; r0 = 0; r1 = 0;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (o_btn[0] != o_btn[1] || o_rise[0] != o_rise[1]) mism++;
      if (o_rise[0]) r0 = c;
      if (o_rise[1]) r1 = c;
    end
    chk("t6_aligned", 32'(mism), 32'd0);
    chk("t6_rise0_at", 32'(r0), 32'd16);
    chk("t6_rise1_at", 32'(r1), 32'd16);
    chk("t6_both_high", 32'(o_btn), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
